// File: rtl/arm_bus_bridge.sv
// ARM asynchronous bus to register-file bridge.
// Every raw ARM/CPLD input is synchronized into the clk domain. A strobe start is
// a synchronized falling edge of rs_n or ws_n with as high. Starts are turned
// into single-cycle reg_rd/reg_wr requests, and read data is returned on arm_d_out.
// Optional feature: define ARM_BUS_TIMEOUT_EN to abort transactions whose strobe
// stays asserted for TIMEOUT_CYC cycles; this sets a sticky timeout_err.
module arm_bus_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] arm_a,
    input  logic [31:0] arm_d_in,
    input  logic [3:0]  arm_be_n,
    input  logic        cpld_rs_n,
    input  logic        cpld_ws_n,
    input  logic        cpld_as,
    output logic [23:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [31:0] reg_rdata,
    input  logic        reg_rvalid,
    output logic [31:0] arm_d_out,
    output logic        arm_d_oe,
    output logic        busy,
    output logic        timeout_err
);

    // Elaboration-time legality checks on the configuration.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("arm_bus_bridge: SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT_CYC < 4 || TIMEOUT_CYC > 65535) begin : g_bad_tmo
        $error("arm_bus_bridge: TIMEOUT_CYC must be 4..65535");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdHold,
        StWrHold
    } state_t;

    state_t state;

    logic [23:0]            a_sync  [SYNC_STAGES];
    logic [31:0]            d_sync  [SYNC_STAGES];
    logic [3:0]             be_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] as_sync;
    logic [SYNC_STAGES-1:0] settle;

    logic [23:0] a_s;
    logic [31:0] d_s;
    logic [3:0]  be_s;
    logic        rs_s;
    logic        ws_s;
    logic        as_s;
    logic        sync_valid;
    logic        rs_prev;
    logic        ws_prev;
    logic        rd_start;
    logic        wr_start;
    logic        tmo_hit;

    // Synchronizer chains; control strobes reset to their idle levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sync[i]  <= '0;
                d_sync[i]  <= '0;
                be_sync[i] <= '0;
            end
            rs_sync <= '1;
            ws_sync <= '1;
            as_sync <= '0;
        end else begin
            a_sync[0]  <= arm_a;
            d_sync[0]  <= arm_d_in;
            be_sync[0] <= arm_be_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i]  <= a_sync[i-1];
                d_sync[i]  <= d_sync[i-1];
                be_sync[i] <= be_sync[i-1];
            end
            rs_sync <= {rs_sync[SYNC_STAGES-2:0], cpld_rs_n};
            ws_sync <= {ws_sync[SYNC_STAGES-2:0], cpld_ws_n};
            as_sync <= {as_sync[SYNC_STAGES-2:0], cpld_as};
        end
    end

    assign a_s  = a_sync[SYNC_STAGES-1];
    assign d_s  = d_sync[SYNC_STAGES-1];
    assign be_s = be_sync[SYNC_STAGES-1];
    assign rs_s = rs_sync[SYNC_STAGES-1];
    assign ws_s = ws_sync[SYNC_STAGES-1];
    assign as_s = as_sync[SYNC_STAGES-1];

    // Tracks when the chains have flushed their reset values and show real inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle <= '0;
        end else begin
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_valid = settle[SYNC_STAGES-1];

    // Previous strobe levels; held low until the chains flush so that a strobe
    // already low when reset releases never looks like a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_prev <= 1'b0;
            ws_prev <= 1'b0;
        end else begin
            rs_prev <= sync_valid & rs_s;
            ws_prev <= sync_valid & ws_s;
        end
    end

    assign rd_start = rs_prev & ~rs_s & as_s;
    assign wr_start = ws_prev & ~ws_s & as_s;

    // Transaction FSM with registered request pulses and read-data drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_be    <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            arm_d_out <= '0;
            arm_d_oe  <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            if (tmo_hit) begin
                state    <= StIdle;
                arm_d_oe <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        // Coincident read and write starts are ambiguous: drop both.
                        if (wr_start && !rd_start) begin
                            reg_addr  <= a_s;
                            reg_wdata <= d_s;
                            reg_be    <= ~be_s;
                            reg_wr    <= 1'b1;
                            state     <= StWrHold;
                        end else if (rd_start && !wr_start) begin
                            reg_addr <= a_s;
                            reg_rd   <= 1'b1;
                            state    <= StRdWait;
                        end
                    end
                    StRdWait: begin
                        if (reg_rvalid) begin
                            arm_d_out <= reg_rdata;
                            arm_d_oe  <= 1'b1;
                            state     <= StRdHold;
                        end
                    end
                    StRdHold: begin
                        if (rs_s || !as_s) begin
                            arm_d_oe <= 1'b0;
                            state    <= StIdle;
                        end
                    end
                    StWrHold: begin
                        if (ws_s) begin
                            state <= StIdle;
                        end
                    end
                    default: begin
                        arm_d_oe <= 1'b0;
                        state    <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy = (state != StIdle);

`ifdef ARM_BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_err;

    // Counts cycles spent outside IDLE; restarts on every return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == StIdle || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state != StIdle) && (tmo_cnt == TMO_LAST);

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_err <= 1'b0;
        end else if (tmo_hit) begin
            tmo_err <= 1'b1;
        end
    end

    assign timeout_err = tmo_err;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_arm_bus_bridge.sv
// Directed self-checking bench for arm_bus_bridge (two-stage synchronizers).
module tb_arm_bus_bridge;

    logic        clk;
    logic        rst;
    logic [23:0] arm_a;
    logic [31:0] arm_d_in;
    logic [3:0]  arm_be_n;
    logic        cpld_rs_n;
    logic        cpld_ws_n;
    logic        cpld_as;
    logic [23:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic [31:0] arm_d_out;
    logic        arm_d_oe;
    logic        busy;
    logic        timeout_err;

    int total;
    int bad;
    int wr_count;
    int rd_count;

    arm_bus_bridge #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm_a      (arm_a),
        .arm_d_in   (arm_d_in),
        .arm_be_n   (arm_be_n),
        .cpld_rs_n  (cpld_rs_n),
        .cpld_ws_n  (cpld_ws_n),
        .cpld_as    (cpld_as),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_be     (reg_be),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .arm_d_out  (arm_d_out),
        .arm_d_oe   (arm_d_oe),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request pulse counters.
    always @(posedge clk) begin
        if (reg_wr === 1'b1) wr_count++;
        if (reg_rd === 1'b1) rd_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [31:0] data,
                            input logic [3:0] be_n);
        arm_a    = addr;
        arm_d_in = data;
        arm_be_n = be_n;
        cpld_as  = 1'b1;
        tick(1);
        cpld_ws_n = 1'b0;
        tick(5);
        cpld_ws_n = 1'b1;
        tick(4);
    endtask

    task automatic start_read(input logic [23:0] addr);
        arm_a   = addr;
        cpld_as = 1'b1;
        tick(1);
        cpld_rs_n = 1'b0;
    endtask

    task automatic wait_rd(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (reg_rd === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL rst_reg_wr got %b want 0", reg_wr); end
        total++; if (reg_rd !== 1'b0) begin bad++; $display("FAIL rst_reg_rd got %b want 0", reg_rd); end
        total++; if (arm_d_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got %b want 0", arm_d_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_tmo got %b want 0", timeout_err); end
        total++; if (reg_addr !== 24'h0) begin bad++; $display("FAIL rst_addr got %h want 0", reg_addr); end
        total++; if (reg_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got %h want 0", reg_wdata); end
        total++; if (reg_be !== 4'h0) begin bad++; $display("FAIL rst_be got %h want 0", reg_be); end
        total++; if (arm_d_out !== 32'h0) begin bad++; $display("FAIL rst_dout got %h want 0", arm_d_out); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_write;
        int w0, r0;
        w0 = wr_count;
        r0 = rd_count;
        do_write(24'h000010, 32'hDEADBEEF, 4'h0);
        total++; if (wr_count - w0 !== 1) begin bad++; $display("FAIL wr_count got %0d want 1", wr_count - w0); end
        total++; if (rd_count - r0 !== 0) begin bad++; $display("FAIL wr_no_rd got %0d want 0", rd_count - r0); end
        total++; if (reg_addr !== 24'h000010) begin bad++; $display("FAIL wr_addr got %h want 000010", reg_addr); end
        total++; if (reg_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got %h want deadbeef", reg_wdata); end
        total++; if (reg_be !== 4'hF) begin bad++; $display("FAIL wr_be got %h want f", reg_be); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_idle got %b want 0", busy); end
        cpld_as = 1'b0;
        tick(2);
    endtask

    task automatic test_byte_write;
        int w0;
        w0 = wr_count;
        do_write(24'h000020, 32'h000000AA, 4'hE);
        total++; if (wr_count - w0 !== 1) begin bad++; $display("FAIL bw_count got %0d want 1", wr_count - w0); end
        total++; if (reg_be !== 4'h1) begin bad++; $display("FAIL bw_be got %h want 1", reg_be); end
        total++; if (reg_wdata !== 32'h000000AA) begin bad++; $display("FAIL bw_data got %h want aa", reg_wdata); end
        cpld_as = 1'b0;
        tick(2);
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = wr_count;
        for (int i = 0; i < 10; i++) begin
            do_write(24'h000100 + 24'(i * 4), 32'(i) * 32'h11111111, 4'h0);
        end
        total++; if (wr_count - w0 !== 10) begin bad++; $display("FAIL b2b_count got %0d want 10", wr_count - w0); end
        total++; if (reg_addr !== 24'h000124) begin bad++; $display("FAIL b2b_addr got %h want 000124", reg_addr); end
        total++; if (reg_wdata !== 32'h99999999) begin bad++; $display("FAIL b2b_data got %h want 99999999", reg_wdata); end
        cpld_as = 1'b0;
        tick(2);
    endtask

    task automatic test_read;
        bit found;
        int r0, w0;
        r0 = rd_count;
        w0 = wr_count;
        start_read(24'h000004);
        wait_rd(found);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rd_req got %b want 1", found); end
        total++; if (reg_addr !== 24'h000004) begin bad++; $display("FAIL rd_addr got %h want 000004", reg_addr); end
        tick(2);
        reg_rvalid = 1'b1;
        reg_rdata  = 32'h12345678;
        tick(1);
        reg_rvalid = 1'b0;
        reg_rdata  = 32'h0;
        total++; if (arm_d_oe !== 1'b1) begin bad++; $display("FAIL rd_oe got %b want 1", arm_d_oe); end
        total++; if (arm_d_out !== 32'h12345678) begin bad++; $display("FAIL rd_dout got %h want 12345678", arm_d_out); end
        tick(1);
        total++; if (arm_d_oe !== 1'b1) begin bad++; $display("FAIL rd_oe_hold got %b want 1", arm_d_oe); end
        total++; if (arm_d_out !== 32'h12345678) begin bad++; $display("FAIL rd_dout_hold got %h want 12345678", arm_d_out); end
        cpld_rs_n = 1'b1;
        tick(3);
        total++; if (arm_d_oe !== 1'b0) begin bad++; $display("FAIL rd_oe_release got %b want 0", arm_d_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_idle got %b want 0", busy); end
        total++; if (rd_count - r0 !== 1) begin bad++; $display("FAIL rd_count got %0d want 1", rd_count - r0); end
        total++; if (wr_count - w0 !== 0) begin bad++; $display("FAIL rd_no_wr got %0d want 0", wr_count - w0); end
        cpld_as = 1'b0;
        tick(2);
    endtask

    task automatic test_simultaneous;
        int w0, r0;
        bit busy_seen;
        arm_a   = 24'h000030;
        cpld_as = 1'b1;
        tick(1);
        w0 = wr_count;
        r0 = rd_count;
        busy_seen = 1'b0;
        cpld_rs_n = 1'b0;
        cpld_ws_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL sim_busy got %b want 0", busy_seen); end
        total++; if (wr_count - w0 !== 0) begin bad++; $display("FAIL sim_wr got %0d want 0", wr_count - w0); end
        total++; if (rd_count - r0 !== 0) begin bad++; $display("FAIL sim_rd got %0d want 0", rd_count - r0); end
        cpld_rs_n = 1'b1;
        cpld_ws_n = 1'b1;
        tick(4);
        cpld_as = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid_read;
        bit found;
        int r0;
        start_read(24'h000008);
        wait_rd(found);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rm_req got %b want 1", found); end
        tick(1);
        reg_rvalid = 1'b1;
        reg_rdata  = 32'hCAFEF00D;
        tick(1);
        reg_rvalid = 1'b0;
        total++; if (arm_d_oe !== 1'b1) begin bad++; $display("FAIL rm_oe_before got %b want 1", arm_d_oe); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (arm_d_oe !== 1'b0) begin bad++; $display("FAIL rm_oe_async got %b want 0", arm_d_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy_async got %b want 0", busy); end
        tick(2);
        rst = 1'b0;
        r0 = rd_count;
        tick(10);
        total++; if (rd_count - r0 !== 0) begin bad++; $display("FAIL rm_no_rd got %0d want 0", rd_count - r0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_stay_idle got %b want 0", busy); end
        cpld_rs_n = 1'b1;
        tick(4);
        cpld_rs_n = 1'b0;
        wait_rd(found);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rm_new_req got %b want 1", found); end
        tick(1);
        reg_rvalid = 1'b1;
        reg_rdata  = 32'h0BADF00D;
        tick(1);
        reg_rvalid = 1'b0;
        reg_rdata  = 32'h0;
        total++; if (arm_d_out !== 32'h0BADF00D) begin bad++; $display("FAIL rm_dout got %h want 0badf00d", arm_d_out); end
        cpld_rs_n = 1'b1;
        tick(4);
        total++; if (arm_d_oe !== 1'b0) begin bad++; $display("FAIL rm_oe_end got %b want 0", arm_d_oe); end
        cpld_as = 1'b0;
        tick(2);
    endtask

    task automatic test_timeout;
        int w0;
        int busy_cycles;
        arm_a    = 24'h000040;
        arm_d_in = 32'h00000055;
        arm_be_n = 4'h0;
        cpld_as  = 1'b1;
        tick(1);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_pre got %b want 0", timeout_err); end
        w0 = wr_count;
        busy_cycles = 0;
        cpld_ws_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy === 1'b1) busy_cycles++;
        end
        total++; if (wr_count - w0 !== 1) begin bad++; $display("FAIL to_wr_count got %0d want 1", wr_count - w0); end
`ifdef ARM_BUS_TIMEOUT_EN
        total++; if (busy_cycles !== 8) begin bad++; $display("FAIL to_busy_cycles got %0d want 8", busy_cycles); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err got %b want 1", timeout_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got %b want 0", busy); end
        cpld_ws_n = 1'b1;
        tick(4);
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got %b want 1", timeout_err); end
`else
        total++; if (busy_cycles !== 18) begin bad++; $display("FAIL nto_busy_cycles got %0d want 18", busy_cycles); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL nto_err got %b want 0", timeout_err); end
        cpld_ws_n = 1'b1;
        tick(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nto_idle got %b want 0", busy); end
`endif
        cpld_as = 1'b0;
        tick(2);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        wr_count   = 0;
        rd_count   = 0;
        rst        = 1'b1;
        arm_a      = '0;
        arm_d_in   = '0;
        arm_be_n   = 4'hF;
        cpld_rs_n  = 1'b1;
        cpld_ws_n  = 1'b1;
        cpld_as    = 1'b0;
        reg_rdata  = '0;
        reg_rvalid = 1'b0;

        test_reset();
        test_write();
        test_byte_write();
        test_back_to_back();
        test_read();
        test_simultaneous();
        test_reset_mid_read();
        test_timeout();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
